// File: rtl/lane_enc_pkg.sv
// rtl/lane_enc_pkg.sv - shared types and constants for the one-hot lane encoder
// Purpose: default payload width, lane count, lane index type, FSM state
//          encoding and the queued request record used by lane_encoder.
// Ports:   none (package).
package lane_enc_pkg;

  localparam int WIDTH = 32;
  localparam int LANES = 4;

  typedef logic [1:0] lane_idx_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } state_t;

  typedef struct packed {
    lane_idx_t        idx;
    logic [WIDTH-1:0] data;
  } entry_t;

endpackage

// File: rtl/lane_enc_fifo.sv
// rtl/lane_enc_fifo.sv - 2-entry request FIFO for the lane encoder
// Purpose: buffers (lane index, word) requests between the input handshake
//          and the presentation FSM.
// Ports:   clk, rst_n (async active-low); push/push_idx/push_data write side;
//          pop read side; head_idx/head_data show the oldest entry;
//          count is the number of stored entries (0..2).
module lane_enc_fifo
  import lane_enc_pkg::*;
#(
  parameter int WIDTH = lane_enc_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  lane_idx_t        push_idx,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output lane_idx_t        head_idx,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count
);

  lane_idx_t        idx_mem  [2];
  logic [WIDTH-1:0] data_mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop    = pop && (count != 2'd0);
  // When full, a simultaneous pop frees the slot the write pointer already
  // points at, so the push can proceed without losing the head.
  assign do_push   = push && ((count != 2'd2) || do_pop);
  assign head_idx  = idx_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      idx_mem[wr_ptr]  <= push_idx;
      data_mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lane_encoder.sv
// rtl/lane_encoder.sv - one-hot lane encoder with request FIFO and zero gap
// Purpose: takes (lane index, word) requests and drives exactly one of four
//          lanes with the word, the rest zero, separated by all-zero gaps.
// Ports:   clk, rst_n (async active-low);
//          in_valid/in_ready/in_idx/in_data request handshake;
//          a0..a3 registered lanes; out_valid/out_ready presentation handshake;
//          err one-cycle pulse for a dropped zero payload;
//          busy while anything is queued or being presented.
module lane_encoder
  import lane_enc_pkg::*;
#(
  parameter int WIDTH      = lane_enc_pkg::WIDTH,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  lane_idx_t        in_idx,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] a0,
  output logic [WIDTH-1:0] a1,
  output logic [WIDTH-1:0] a2,
  output logic [WIDTH-1:0] a3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err,
  output logic             busy
);

  localparam logic [3:0] GAP_LOAD = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           state;
  logic [3:0]       gap_cnt;
  logic [WIDTH-1:0] lane_q [LANES];
  logic [1:0]       count;
  lane_idx_t        head_idx;
  logic [WIDTH-1:0] head_data;
  logic             accept;
  logic             push;
  logic             pop;

  // in_ready comes from the registered count only, never from out_ready.
  assign in_ready = (count != 2'd2);
  assign busy     = (count != 2'd0) || (state != IDLE);
  assign accept   = in_valid && in_ready;
  // A zero word would be invisible to the decoder, so it is dropped.
  assign push     = accept && (in_data != '0);
  assign pop      = (state == IDLE) && (count != 2'd0);

  assign a0 = lane_q[0];
  assign a1 = lane_q[1];
  assign a2 = lane_q[2];
  assign a3 = lane_q[3];

  lane_enc_fifo #(.WIDTH(WIDTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_idx  (in_idx),
    .push_data (in_data),
    .pop       (pop),
    .head_idx  (head_idx),
    .head_data (head_data),
    .count     (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gap_cnt   <= 4'd0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      for (int i = 0; i < LANES; i++) lane_q[i] <= '0;
    end else begin
      err <= accept && (in_data == '0);
      case (state)
        IDLE: begin
          if (count != 2'd0) begin
            for (int i = 0; i < LANES; i++)
              lane_q[i] <= (head_idx == lane_idx_t'(i)) ? head_data : '0;
            out_valid <= 1'b1;
            state     <= PRESENT;
          end
        end
        PRESENT: begin
          if (out_ready) begin
            for (int i = 0; i < LANES; i++) lane_q[i] <= '0;
            out_valid <= 1'b0;
            if (GAP_CYCLES > 0) begin
              gap_cnt <= GAP_LOAD;
              state   <= GAP;
            end else begin
              state <= IDLE;
            end
          end
        end
        GAP: begin
          if (gap_cnt == 4'd0) state <= IDLE;
          else                 gap_cnt <= gap_cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lane_encoder.sv
// tb/tb_lane_encoder.sv - scoreboard bench for lane_encoder (gap 1 and gap 0 instances)
module tb_lane_encoder;
  import lane_enc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid  [2];
  logic        in_ready  [2];
  lane_idx_t   in_idx    [2];
  logic [31:0] in_data   [2];
  logic [31:0] lane      [2][4];
  logic        out_valid [2];
  logic        out_ready [2];
  logic        err       [2];
  logic        busy      [2];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  entry_t exp_q0[$];
  entry_t exp_q1[$];
  int     hs0[$];
  int     hs1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Index 0: GAP_CYCLES = 0, index 1: GAP_CYCLES = 1
  lane_encoder #(.WIDTH(32), .GAP_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_idx(in_idx[0]), .in_data(in_data[0]), .a0(lane[0][0]), .a1(lane[0][1]),
    .a2(lane[0][2]), .a3(lane[0][3]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .err(err[0]), .busy(busy[0])
  );

  lane_encoder #(.WIDTH(32), .GAP_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_idx(in_idx[1]), .in_data(in_data[1]), .a0(lane[1][0]), .a1(lane[1][1]),
    .a2(lane[1][2]), .a3(lane[1][3]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .err(err[1]), .busy(busy[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: invariant every cycle, scoreboard pop on each presentation handshake
  always @(negedge clk) begin
    int     nz;
    entry_t obs;
    entry_t e;
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        nz  = 0;
        obs = '0;
        for (int l = 0; l < 4; l++) begin
          if (lane[d][l] != 32'd0) begin
            nz++;
            obs.idx  = lane_idx_t'(l);
            obs.data = lane[d][l];
          end
        end
        tests++;
        assert (nz <= 1 && (out_valid[d] || nz == 0)) else begin
          fails++;
          $display("FAIL lane_invariant dut%0d cyc %0d: %0d nonzero lanes with out_valid=%0b, expected <=1 and 0 when not valid",
                   d, cyc, nz, out_valid[d]);
        end
        if (out_valid[d] && out_ready[d]) begin
          if ((d == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0)) begin
            tests++;
            fails++;
            $display("FAIL unexpected_present dut%0d: got idx %0d data 0x%0h, expected no presentation",
                     d, obs.idx, obs.data);
          end else begin
            e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk($sformatf("present_idx_dut%0d", d), 32'(obs.idx), 32'(e.idx));
            chk($sformatf("present_data_dut%0d", d), obs.data, e.data);
          end
          if (d == 0) hs0.push_back(cyc);
          else        hs1.push_back(cyc);
        end
      end
    end
  end

  task automatic send(input int d, input lane_idx_t idx, input logic [31:0] data);
    entry_t e;
    int     n = 0;
    in_valid[d] = 1'b1;
    in_idx[d]   = idx;
    in_data[d]  = data;
    while (!in_ready[d] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready[d]) begin
      tests++;
      fails++;
      $display("FAIL send_timeout dut%0d: in_ready stayed 0, expected 1", d);
      in_valid[d] = 1'b0;
      return;
    end
    if (data != 32'd0) begin
      e.idx  = idx;
      e.data = data;
      if (d == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
    end
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d, input int limit);
    int n = 0;
    while (busy[d] && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("drain_busy_dut%0d", d), 32'(busy[d]), 0);
    chk($sformatf("drain_queue_dut%0d", d), (d == 0) ? exp_q0.size() : exp_q1.size(), 0);
  endtask

  task automatic chk_spacing(input string name, input int d, input int n, input int gap);
    int sz;
    sz = (d == 0) ? hs0.size() : hs1.size();
    chk({name, "_count"}, sz, n);
    for (int i = 1; i < sz; i++)
      chk($sformatf("%s_spacing%0d", name, i),
          (d == 0) ? hs0[i] - hs0[i-1] : hs1[i] - hs1[i-1], gap);
  endtask

  lane_idx_t   t4_idx  [6] = '{2'd3, 2'd0, 2'd2, 2'd1, 2'd3, 2'd2};
  logic [31:0] t4_data [6] = '{32'h1000_0001, 32'h2000_0002, 32'h3000_0003,
                               32'h4000_0004, 32'h5000_0005, 32'h6000_0006};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 1'b0;
      in_idx[d]    = 2'd0;
      in_data[d]   = 32'd0;
      out_ready[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    for (int l = 0; l < 4; l++) chk($sformatf("rst_a%0d", l), lane[1][l], 0);
    chk("rst_out_valid", 32'(out_valid[1]), 0);
    chk("rst_err", 32'(err[1]), 0);
    chk("rst_in_ready", 32'(in_ready[1]), 1);
    chk("rst_busy", 32'(busy[1]), 0);
    chk("rst_in_ready_dut0", 32'(in_ready[0]), 1);

    // Single word: presented one edge after accept, taken, then one zero cycle
    out_ready[1] = 1'b1;
    send(1, 2'd2, 32'h0000_00A5);
    @(posedge clk); #1;
    chk("t1_a2", lane[1][2], 32'hA5);
    chk("t1_a0", lane[1][0], 0);
    chk("t1_a1", lane[1][1], 0);
    chk("t1_a3", lane[1][3], 0);
    chk("t1_out_valid", 32'(out_valid[1]), 1);
    @(posedge clk); #1;
    chk("t1_gap_valid", 32'(out_valid[1]), 0);
    chk("t1_gap_a2", lane[1][2], 0);
    chk("t1_gap_busy", 32'(busy[1]), 1);
    @(posedge clk); #1;
    chk("t1_idle_busy", 32'(busy[1]), 0);

    // Zero payload: dropped with a single err pulse
    send(1, 2'd1, 32'd0);
    chk("t2_err_high", 32'(err[1]), 1);
    chk("t2_busy", 32'(busy[1]), 0);
    chk("t2_out_valid", 32'(out_valid[1]), 0);
    @(posedge clk); #1;
    chk("t2_err_low", 32'(err[1]), 0);
    chk("t2_busy_after", 32'(busy[1]), 0);

    // Back-pressure: one presenting, two queued, fourth request refused
    out_ready[1] = 1'b0;
    send(1, 2'd0, 32'h11);
    send(1, 2'd1, 32'h22);
    send(1, 2'd3, 32'h33);
    chk("t3_in_ready_full", 32'(in_ready[1]), 0);
    chk("t3_hold_a0", lane[1][0], 32'h11);
    chk("t3_hold_valid", 32'(out_valid[1]), 1);
    in_valid[1] = 1'b1;
    in_idx[1]   = 2'd2;
    in_data[1]  = 32'h44;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("t3_refuse%0d", i), 32'(in_ready[1]), 0);
    end
    in_valid[1] = 1'b0;
    hs1.delete();
    out_ready[1] = 1'b1;
    wait_idle(1, 40);
    chk_spacing("t3", 1, 3, 3);

    // Continuous stream: simultaneous push/pop, pointer wrap, 3-cycle period
    hs1.delete();
    for (int i = 0; i < 6; i++) send(1, t4_idx[i], t4_data[i]);
    wait_idle(1, 60);
    chk_spacing("t4", 1, 6, 3);

    // Zero-gap instance: one presentation every 2 cycles
    out_ready[0] = 1'b1;
    hs0.delete();
    send(0, 2'd1, 32'hA1);
    send(0, 2'd3, 32'hB2);
    send(0, 2'd0, 32'hC3);
    send(0, 2'd2, 32'hD4);
    send(0, 2'd1, 32'hE5);
    wait_idle(0, 60);
    chk_spacing("t5", 0, 5, 2);

    // Asynchronous reset mid-presentation with two words queued
    out_ready[1] = 1'b0;
    send(1, 2'd2, 32'h77);
    send(1, 2'd0, 32'h88);
    send(1, 2'd1, 32'h99);
    #3 rst_n = 1'b0;
    #1;
    for (int l = 0; l < 4; l++) chk($sformatf("t6_a%0d", l), lane[1][l], 0);
    chk("t6_out_valid", 32'(out_valid[1]), 0);
    chk("t6_in_ready", 32'(in_ready[1]), 1);
    chk("t6_busy", 32'(busy[1]), 0);
    exp_q1.delete();
    @(posedge clk); #3;
    rst_n = 1'b1;
    out_ready[1] = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("t6_no_stale_valid", 32'(out_valid[1]), 0);
    chk("t6_no_stale_busy", 32'(busy[1]), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
